// File: rtl/priority_arbiter8.sv
// Eight-way request arbiter with fixed or rotating priority, a hold limit,
// and a mandatory one-cycle gap between grants.
module priority_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nx;
    logic [2:0] last_id;
    logic [2:0] last_nx;
    logic [7:0] gnt_nx;
    logic [2:0] id_nx;
    logic       valid_nx;
    logic       to_nx;

    logic [2:0] win_id;
    logic       win_found;
    logic [2:0] scan_idx;

    // Scan order: fixed starts at 7; rotating starts just below last_id
    // and ends on last_id itself, so the previous winner ranks lowest.
    always_comb begin
        win_id    = 3'd0;
        win_found = 1'b0;
        scan_idx  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = rr_en ? (last_id - 3'(k)) : 3'(8 - k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        last_nx  = last_id;
        gnt_nx   = gnt;
        id_nx    = gnt_id;
        valid_nx = gnt_valid;
        to_nx    = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx   = 8'd0;
                id_nx    = 3'd0;
                valid_nx = 1'b0;
                if (win_found) begin
                    gnt_nx   = 8'd1 << win_id;
                    id_nx    = win_id;
                    valid_nx = 1'b1;
                    hold_nx  = 8'd0;
                    last_nx  = win_id;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_id] || hold_cnt == HOLD_LAST) begin
                    // Release wins over the limit when both hit together.
                    to_nx    = req[gnt_id];
                    gnt_nx   = 8'd0;
                    id_nx    = 3'd0;
                    valid_nx = 1'b0;
                    hold_nx  = 8'd0;
                    state_nx = GAP;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            GAP: begin
                gnt_nx   = 8'd0;
                id_nx    = 3'd0;
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                gnt_nx   = 8'd0;
                id_nx    = 3'd0;
                valid_nx = 1'b0;
                hold_nx  = 8'd0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            last_id   <= 3'd0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            last_id   <= last_nx;
            gnt       <= gnt_nx;
            gnt_id    <= id_nx;
            gnt_valid <= valid_nx;
            timeout   <= to_nx;
        end
    end

endmodule

// File: tb/tb_priority_arbiter8.sv
// Bench for priority_arbiter8: vector table, directed corner sequences,
// then random traffic against a behavioural model.
module tb_priority_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       rr_en = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad = 0;

    priority_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model: owner index (-1 = none), cycles already shown, gap flag.
    int m_owner;
    int m_held;
    int m_last;
    bit m_gap;
    bit m_to;

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic int pick(logic [7:0] r, logic rr);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = rr ? (m_last + 8 - k) % 8 : 8 - k;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_step(logic [7:0] r, logic rr);
        int w;
        m_to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held == MH) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            w = pick(r, rr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end
        end
    endfunction

    task automatic check(string nm, logic [7:0] eg, logic [2:0] ei,
                         logic ev, logic et);
        total++;
        if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev ||
            timeout !== et) begin
            bad++;
            $display("FAIL %s: got gnt=%h id=%0d v=%0b to=%0b want gnt=%h id=%0d v=%0b to=%0b",
                     nm, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    task automatic check_model(string nm);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
        ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check(nm, eg, ei, m_owner >= 0, m_to);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(req, rr_en);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        rr_en = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 8'd0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rr;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[10];

    initial begin
        model_reset();
        // Fixed-priority pick, then a held requester hitting the limit.
        tbl[0] = '{8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[1] = '{8'h0C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2] = '{8'h0C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3] = '{8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[4] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[5] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[6] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[7] = '{8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[8] = '{8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[9] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            req   = tbl[i].req;
            rr_en = tbl[i].rr;
            step();
            check($sformatf("tbl%0d", i), tbl[i].g, tbl[i].id,
                  tbl[i].v, tbl[i].to);
        end

        // Other requests ignored while a grant is held.
        do_reset();
        req = 8'h04;
        step();
        check("hold_g2", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h44;
        step();
        check("ign6_a", 8'h04, 3'd2, 1'b1, 1'b0);
        step();
        check("ign6_b", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h40;
        step();
        check("rel2_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        check("rel2_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        check("next6", 8'h40, 3'd6, 1'b1, 1'b0);

        // Release on the limit edge counts as release.
        do_reset();
        req = 8'h02;
        for (int i = 0; i < MH; i++) begin
            step();
            check("lim_hold", 8'h02, 3'd1, 1'b1, 1'b0);
        end
        req = 8'h00;
        step();
        check("lim_release", 8'h00, 3'd0, 1'b0, 1'b0);

        // Async reset mid-grant, then rotating pick after reset.
        do_reset();
        req = 8'h10;
        step();
        check("g4", 8'h10, 3'd4, 1'b1, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        model_reset();
        req   = 8'h01;
        rr_en = 1'b1;
        step();
        check("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

        // First rotating search after reset starts at 7.
        do_reset();
        rr_en = 1'b1;
        req   = 8'h81;
        step();
        check("rr_first7", 8'h80, 3'd7, 1'b1, 1'b0);

        // Rotating order with all lines requesting.
        do_reset();
        rr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] e;
            e = 3'((15 - i) % 8);
            req = 8'hFF;
            step();
            check($sformatf("rr_g%0d", i), 8'(1 << e), e, 1'b1, 1'b0);
            req = 8'hFF & ~8'(1 << e);
            step();
            check("rr_gap", 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
            step();
            check("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      req = 8'd0;
            else if (r < 40) req = 8'($urandom);
            else if (r < 50) req = req | 8'(1 << $urandom_range(0, 7));
            rr_en = ($urandom_range(0, 3) != 0);
            step();
            check_model("rand");
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_rst", 8'h00, 3'd0, 1'b0, 1'b0);
                #1;
                rst_n = 1'b1;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
